// File: rtl/fm_pkg.sv
// Shared definitions for the feature-map routers: FSM encodings, default
// array geometry and a constant-foldable log2 helper.
package fm_pkg;

  localparam int unsigned POX_DEF = 32;
  localparam int unsigned POY_DEF = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic int unsigned log2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Layer configuration, tile/y-group counters, row base address and
// right-edge lane mask for the OFM writer.
module ofm_addr_gen
  import fm_pkg::*;
#(
  parameter int unsigned pox = POX_DEF,
  parameter int unsigned poy = POY_DEF,
  parameter int unsigned AW  = 16,
  parameter int unsigned RW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_load,
  input  logic [7:0]    ox_set,
  input  logic [7:0]    oy_set,
  input  logic [AW-1:0] base_set,
  input  logic          start,
  input  logic          advance,
  output logic [AW-1:0] tile_addr,
  output logic [7:0]    ntx,
  output logic [pox-1:0] mask,
  output logic [RW-1:0] rows_k,
  output logic          last_beat,
  output logic          cfg_empty
);

  localparam int unsigned PL = log2_u(pox);

  logic [7:0]    ox_q, ox_d, oy_q, oy_d, ntx_q, ntx_d, tx_q, tx_d;
  logic [15:0]   yg_q, yg_d;
  logic [AW-1:0] base_q, base_d, step_q, step_d, row_base_q, row_base_d;
  int unsigned   ntx_calc, px, rem;

  always_comb begin
    ox_d       = ox_q;
    oy_d       = oy_q;
    base_d     = base_q;
    ntx_d      = ntx_q;
    step_d     = step_q;
    tx_d       = tx_q;
    yg_d       = yg_q;
    row_base_d = row_base_q;
    ntx_calc   = (32'(ox_set) + pox - 1) >> PL;
    if (cfg_load) begin
      ox_d   = ox_set;
      oy_d   = oy_set;
      base_d = base_set;
      ntx_d  = 8'(ntx_calc);
      // y-group stride poy*ntx built by repeated addition
      step_d = '0;
      for (int unsigned i = 0; i < poy; i++) step_d = step_d + AW'(ntx_d);
    end
    if (start) begin
      tx_d       = '0;
      yg_d       = '0;
      row_base_d = base_q;
    end else if (advance) begin
      if (tx_q == ntx_q - 8'd1) begin
        tx_d       = '0;
        yg_d       = yg_q + 16'(poy);
        row_base_d = row_base_q + step_q;
      end else begin
        tx_d = tx_q + 8'd1;
      end
    end
  end

  always_comb begin
    mask      = '0;
    tile_addr = row_base_q + AW'(tx_q);
    ntx       = ntx_q;
    px        = 32'(tx_q) << PL;
    for (int unsigned i = 0; i < pox; i++) mask[i] = (px + i) < 32'(ox_q);
    rem       = (32'(yg_q) < 32'(oy_q)) ? (32'(oy_q) - 32'(yg_q)) : 32'd0;
    rows_k    = RW'((rem < poy) ? rem : poy);
    last_beat = (tx_q == ntx_q - 8'd1) && ((32'(yg_q) + poy) >= 32'(oy_q));
    cfg_empty = (ox_q == '0) || (oy_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ox_q       <= '0;
      oy_q       <= '0;
      base_q     <= '0;
      ntx_q      <= '0;
      step_q     <= '0;
      tx_q       <= '0;
      yg_q       <= '0;
      row_base_q <= '0;
    end else begin
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      base_q     <= base_d;
      ntx_q      <= ntx_d;
      step_q     <= step_d;
      tx_q       <= tx_d;
      yg_q       <= yg_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/ofm_data_writer.sv
// Serialises poy-row OFM beats from the PE array onto the single FM buffer
// write port with row-major tiled addressing and right-edge lane masking.
module ofm_data_writer
  import fm_pkg::*;
#(
  parameter int unsigned pox = POX_DEF,
  parameter int unsigned poy = POY_DEF,
  parameter int unsigned AW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic [7:0]           ox_set,
  input  logic [7:0]           oy_set,
  input  logic [AW-1:0]        base_addr_set,
  input  logic                 en,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [pox*poy*8-1:0] in_data,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [pox*8-1:0]     wr_data,
  output logic [pox-1:0]       wr_mask
);

  localparam int unsigned RW = log2_u(poy + 1);
  localparam int unsigned RB = pox * 8;

  logic [1:0]           state_q, state_d;
  logic [pox*poy*8-1:0] hold_q, hold_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [RB-1:0]        wr_data_q, wr_data_d;
  logic [pox-1:0]       wr_mask_q, wr_mask_d;

  logic                 cfg_load, start, advance, last_beat, cfg_empty;
  logic [AW-1:0]        tile_addr;
  logic [7:0]           ntx;
  logic [pox-1:0]       mask;
  logic [RW-1:0]        rows_k;

  ofm_addr_gen #(.pox(pox), .poy(poy), .AW(AW), .RW(RW)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .cfg_load (cfg_load),
    .ox_set   (ox_set),
    .oy_set   (oy_set),
    .base_set (base_addr_set),
    .start    (start),
    .advance  (advance),
    .tile_addr(tile_addr),
    .ntx      (ntx),
    .mask     (mask),
    .rows_k   (rows_k),
    .last_beat(last_beat),
    .cfg_empty(cfg_empty)
  );

  // Row 0 is registered on the handshake edge so writes land in N+1..N+k;
  // the final row of the final beat jumps straight to DONE to keep done at
  // one cycle after the last write.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    row_d     = row_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    done_d    = 1'b0;
    cfg_load  = 1'b0;
    start     = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_load = set;
        if (en) begin
          start   = 1'b1;
          state_d = cfg_empty ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          hold_d    = in_data;
          row_d     = RW'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = tile_addr;
          wr_data_d = in_data[RB-1:0];
          wr_mask_d = mask;
          state_d   = ((rows_k == RW'(1)) && last_beat) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (row_q < rows_k) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + AW'(ntx);
          for (int unsigned r = 0; r < poy; r++) begin
            if (RW'(r) == row_q) wr_data_d = hold_q[r*RB +: RB];
          end
          wr_mask_d = mask;
          row_d     = row_q + RW'(1);
          if ((row_q + RW'(1) == rows_k) && last_beat) state_d = ST_DONE;
        end else begin
          advance = 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      row_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      row_q     <= row_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign in_ready = (state_q == ST_ACCEPT);
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_mask  = wr_mask_q;

endmodule

// File: tb/tb_ofm_data_writer.sv
// Directed bench for ofm_data_writer: expected write tables per layer plus
// hand-written sequences for latency, reset abort and empty-layer cases.
module tb_ofm_data_writer;

  localparam int unsigned POX = 32;
  localparam int unsigned POY = 3;
  localparam int unsigned AW  = 16;

  logic                 clk = 1'b0;
  logic                 rst, set, en, in_valid;
  logic [7:0]           ox_set, oy_set;
  logic [AW-1:0]        base_addr_set;
  logic [POX*POY*8-1:0] in_data;
  logic                 busy, done, in_ready, wr_en;
  logic [AW-1:0]        wr_addr;
  logic [POX*8-1:0]     wr_data;
  logic [POX-1:0]       wr_mask;

  always #5 clk = ~clk;

  ofm_data_writer #(.pox(POX), .poy(POY), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .set          (set),
    .ox_set       (ox_set),
    .oy_set       (oy_set),
    .base_addr_set(base_addr_set),
    .en           (en),
    .busy         (busy),
    .done         (done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0]    q_addr[$];
  logic [POX*8-1:0] q_data[$];
  logic [POX-1:0]   q_mask[$];
  int               q_wcyc[$];
  int               q_hs[$];
  int done_cnt = 0, done_cyc = 0, en_cyc = 0, ready_in_write = 0, busy_with_done = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_mask.push_back(wr_mask);
      q_wcyc.push_back(cyc);
    end
    if (in_valid && in_ready) q_hs.push_back(cyc);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (en) en_cyc <= cyc;
    if (wr_en && in_ready) ready_in_write <= ready_in_write + 1;
    if (done && busy) busy_with_done <= busy_with_done + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endtask

  function automatic logic [POX*8-1:0] row_pat(input int seed, input int r);
    logic [POX*8-1:0] v;
    for (int i = 0; i < POX; i++) v[i*8 +: 8] = 8'((seed * 37 + r * 11 + i * 3 + 5) % 256);
    return v;
  endfunction

  function automatic logic [POX*POY*8-1:0] beat_pat(input int seed);
    logic [POX*POY*8-1:0] d;
    for (int r = 0; r < POY; r++) d[r*POX*8 +: POX*8] = row_pat(seed, r);
    return d;
  endfunction

  typedef struct {
    logic [AW-1:0]  addr;
    logic [POX-1:0] mask;
    int             beat;
    int             row;
  } wvec_t;

  wvec_t tab[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] ox, input logic [7:0] oy, input logic [AW-1:0] base);
    ox_set = ox; oy_set = oy; base_addr_set = base; set = 1'b1;
    tick();
    set = 1'b0;
  endtask

  task automatic start();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic send_beat(input int seed, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = beat_pat(seed);
    t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk_i("ready_timeout", t, 0);
    tick();
    in_valid = 1'b0;
    in_data  = ~in_data;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      tick();
      t++;
    end
    chk_i("done_pulse", done_cnt - d0, 1);
  endtask

  task automatic run_layer(input logic [7:0] ox, input logic [7:0] oy, input logic [AW-1:0] base,
                           input int nb, input int salt, input int gmax, input bit busy_set);
    int d0;
    d0 = done_cnt;
    configure(ox, oy, base);
    start();
    if (busy_set) begin
      ox_set = 8'd8; set = 1'b1;
      tick();
      set = 1'b0; ox_set = ox;
    end
    for (int b = 0; b < nb; b++)
      send_beat(salt + b, (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    wait_done(d0);
  endtask

  task automatic check_writes(input string tag, input int w0, input int first, input int n, input int salt);
    chk_i({tag, "_count"}, q_addr.size() - w0, n);
    for (int k = 0; k < n; k++) begin
      if (w0 + k < q_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, k), 256'(q_addr[w0+k]), 256'(tab[first+k].addr));
        chk($sformatf("%s_mask%0d", tag, k), 256'(q_mask[w0+k]), 256'(tab[first+k].mask));
        chk($sformatf("%s_data%0d", tag, k), 256'(q_data[w0+k]),
            256'(row_pat(salt + tab[first+k].beat, tab[first+k].row)));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w0, h0, d0;
    // ox=64 oy=3 base=0x100 (entries 0..5); ox=40 oy=4 base=0 (entries 6..13)
    tab[0]  = '{16'h100, 32'hFFFF_FFFF, 0, 0};
    tab[1]  = '{16'h102, 32'hFFFF_FFFF, 0, 1};
    tab[2]  = '{16'h104, 32'hFFFF_FFFF, 0, 2};
    tab[3]  = '{16'h101, 32'hFFFF_FFFF, 1, 0};
    tab[4]  = '{16'h103, 32'hFFFF_FFFF, 1, 1};
    tab[5]  = '{16'h105, 32'hFFFF_FFFF, 1, 2};
    tab[6]  = '{16'h000, 32'hFFFF_FFFF, 0, 0};
    tab[7]  = '{16'h002, 32'hFFFF_FFFF, 0, 1};
    tab[8]  = '{16'h004, 32'hFFFF_FFFF, 0, 2};
    tab[9]  = '{16'h001, 32'h0000_00FF, 1, 0};
    tab[10] = '{16'h003, 32'h0000_00FF, 1, 1};
    tab[11] = '{16'h005, 32'h0000_00FF, 1, 2};
    tab[12] = '{16'h006, 32'hFFFF_FFFF, 2, 0};
    tab[13] = '{16'h007, 32'h0000_00FF, 3, 0};

    rst = 1'b1; set = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
    ox_set = '0; oy_set = '0; base_addr_set = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_wr_en", 256'(wr_en), 256'(0));
    chk("rst_wr_addr", 256'(wr_addr), 256'(0));
    chk("rst_wr_mask", 256'(wr_mask), 256'(0));
    chk("rst_wr_data", 256'(wr_data), 256'(0));

    // Full-width layer, back-to-back beats
    w0 = q_addr.size(); h0 = q_hs.size();
    run_layer(8'd64, 8'd3, 16'h100, 2, 0, 0, 1'b0);
    check_writes("s1", w0, 0, 6, 0);
    if (q_hs.size() >= h0 + 2 && q_addr.size() >= w0 + 6) begin
      chk_i("s1_first_write_lat", q_wcyc[w0] - q_hs[h0], 1);
      chk_i("s1_beat_interval", q_hs[h0+1] - q_hs[h0], 4);
      chk_i("s1_done_after_last", done_cyc - q_wcyc[w0+5], 1);
    end else begin
      chk_i("s1_capture", 0, 1);
    end

    // Stray in_valid in IDLE must not be taken
    w0 = q_addr.size(); h0 = q_hs.size(); d0 = done_cnt;
    in_valid = 1'b1; in_data = beat_pat(99);
    repeat (4) tick();
    chk("idle_in_ready", 256'(in_ready), 256'(0));
    in_valid = 1'b0;
    tick();
    chk_i("idle_no_hs", q_hs.size() - h0, 0);
    chk_i("idle_no_write", q_addr.size() - w0, 0);
    chk_i("idle_no_done", done_cnt - d0, 0);

    // set while busy is ignored
    w0 = q_addr.size();
    run_layer(8'd64, 8'd3, 16'h100, 2, 0, 0, 1'b1);
    check_writes("s6", w0, 0, 6, 0);

    // Partial right tile and partial last y-group
    w0 = q_addr.size();
    run_layer(8'd40, 8'd4, 16'h000, 4, 10, 0, 1'b0);
    check_writes("s2", w0, 6, 8, 10);

    // Random valid gaps
    w0 = q_addr.size();
    run_layer(8'd64, 8'd3, 16'h100, 2, 0, 3, 1'b0);
    check_writes("s3", w0, 0, 6, 0);
    chk_i("ready_during_write", ready_in_write, 0);

    // Reset on the second DRAIN cycle
    w0 = q_addr.size(); d0 = done_cnt;
    configure(8'd64, 8'd3, 16'h100);
    start();
    chk("s4_busy_after_en", 256'(busy), 256'(1));
    send_beat(50, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk_i("s4_write_count", q_addr.size() - w0, 2);
    chk("s4_busy", 256'(busy), 256'(0));
    chk("s4_in_ready", 256'(in_ready), 256'(0));
    chk_i("s4_no_done", done_cnt - d0, 0);
    if (q_addr.size() >= w0 + 2) begin
      chk("s4_addr0", 256'(q_addr[w0]), 256'(16'h100));
      chk("s4_addr1", 256'(q_addr[w0+1]), 256'(16'h102));
    end
    w0 = q_addr.size();
    run_layer(8'd64, 8'd3, 16'h100, 2, 0, 0, 1'b0);
    check_writes("s4_rerun", w0, 0, 6, 0);

    // Empty layer: zero writes, done two cycles after en
    w0 = q_addr.size(); d0 = done_cnt;
    configure(8'd0, 8'd5, 16'h000);
    start();
    wait_done(d0);
    chk_i("s5_done_latency", done_cyc - en_cyc, 2);
    chk_i("s5_writes", q_addr.size() - w0, 0);
    chk_i("busy_low_with_done", busy_with_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
